frecuencimetro_multi: RTL and testbench
=======================================

Name: frecuencimetro_multi

Overview:
Parametrised multi-channel frequency meter. It counts rising edges on CHANNELS asynchronous input signals over a gate window. At each gate event it latches every channel's count into a packed output bus and pulses valid. The gate is either an internal cycle timer or an external one-cycle gate pulse. It sits between the input pins and the display/readout logic and adds synchronisation, saturation, overflow flags and discarding of partial windows.

Parameters:
WIDTH, 16, bits per channel count
CHANNELS, 4, number of measured inputs
GATE_CYCLES, 50000000, clock cycles per internal gate window (1 s at 50 MHz); must be >= 2
SYNC_STAGES, 2, flip-flop stages in each input synchroniser; must be >= 2

Ports:
clock  in  1  system clock; all logic on its rising edge
reset_n  in  1  asynchronous, active-low reset
enable  in  1  1 = measure, 0 = idle
gate_sel  in  1  0 = internal timer gate, 1 = external gate_ext
gate_ext  in  1  external gate pulse, synchronous to clock, one cycle high per window end
senal  in  CHANNELS  asynchronous input signals to measure
numero  out  CHANNELS*WIDTH  latched counts; channel k occupies bits [k*WIDTH +: WIDTH]
overflow  out  CHANNELS  latched per-channel saturation flag for the last window
valid  out  1  one-cycle pulse when numero/overflow update
gate_tick  out  1  one-cycle pulse on every selected gate event, including discarded ones

Behaviour:
- Reset (reset_n=0, asynchronous): numero=0, overflow=0, valid=0, gate_tick=0. All counters, synchronisers, timer and edge history are cleared. State=IDLE. Mid-window reset discards the window.
- Input path:
  - Each senal bit passes through SYNC_STAGES flops, then a one-flop edge detector.
  - A rising edge is a sync=1 with previous=0.
  - Latency from pin transition to counter increment is SYNC_STAGES+1 cycles.
  - Pulses shorter than one clock period may be missed; this is acceptable.
- Internal timer: counts 0..GATE_CYCLES-1. It produces gate event tick_int when at GATE_CYCLES-1, then wraps to 0. It runs only when state is not IDLE and gate_sel=0.
- Gate event: gate = gate_sel ? gate_ext : tick_int. gate_tick = gate registered, so it is 1 cycle late and aligned with valid.
- Counters:
  - Per channel, WIDTH bits, saturating at 2^WIDTH-1.
  - Overflow sticky bit is set when an edge arrives with the counter already at maximum.
  - On a gate cycle, the counter reloads to 1 if an edge is present in that cycle, else to 0. The edge therefore belongs to the new window; no edge is lost. Sticky overflow is cleared at the same time.
- State machine:
  - IDLE: counters and timer held at 0. Go to ARMING when enable=1.
  - ARMING: counting, but the window is partial. On gate, clear counters, set valid=0, go to MEASURING.
  - MEASURING: on gate, numero<=counts, overflow<=sticky bits, valid=1 for one cycle (registered, same cycle as gate_tick). Stay in MEASURING.
  - Any state: enable=0 goes to IDLE next cycle. A change of gate_sel (detected against its registered copy) goes to ARMING and clears the timer and counters.
- numero and overflow hold their last values in IDLE/ARMING; only reset clears them.
- Simultaneous gate and gate_sel change: the gate_sel change wins; no valid is produced.
- gate_ext is ignored when gate_sel=0; tick_int is ignored when gate_sel=1.
- Width rule: the latched count is exact when edges < 2^WIDTH, otherwise it is 2^WIDTH-1 with overflow=1.

Test Plan:
1. Hold reset_n=0 with senal toggling, release with enable=0 → numero=0, overflow=0, valid=0, gate_tick=0 indefinitely.
2. GATE_CYCLES=100, gate_sel=0, enable=1, senal[0] rising every 10 clocks, others 0 → first tick gives no valid; then valid every 100 cycles with channel 0 =10, channels 1..3 =0, overflow=0.
3. WIDTH=4, GATE_CYCLES=100, senal[1] rising every 4 clocks → numero ch1=15, overflow[1]=1. Change to 5 edges per window → next latch ch1=5, overflow[1]=0.
4. gate_sel=1, gate_ext pulses 50 cycles apart, with a synchronised edge on ch2 landing exactly on a gate_ext cycle → that edge is counted in the following window (sum over windows equals total edges); valid aligned with gate_tick.
5. In MEASURING, toggle gate_sel mid-window → next gate event gives gate_tick=1, valid=0. The window after that reports a correct full count; numero holds its previous value meanwhile.
6. Assert reset_n=0 for 1 cycle mid-window after numero=10 → numero=0 immediately (asynchronous). After release, the first gate is discarded and the next window reports the correct count.

Source files
------------

// File: rtl/frecuencimetro_multi.sv
// Multi-channel frequency meter: counts synchronised rising edges per channel
// over an internal or external gate window and latches the counts at each gate.
module frecuencimetro_multi #(
  parameter int WIDTH       = 16,
  parameter int CHANNELS    = 4,
  parameter int GATE_CYCLES = 50000000,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic                      gate_sel,
  input  logic                      gate_ext,
  input  logic [CHANNELS-1:0]       senal,
  output logic [CHANNELS*WIDTH-1:0] numero,
  output logic [CHANNELS-1:0]       overflow,
  output logic                      valid,
  output logic                      gate_tick
);

  localparam int              TW         = $clog2(GATE_CYCLES);
  localparam logic [TW-1:0]   TIMER_LAST = TW'(GATE_CYCLES - 1);
  localparam logic [WIDTH-1:0] COUNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, ARMING, MEASURING} state_t;

  state_t                              state_q, state_d;
  logic [CHANNELS-1:0][SYNC_STAGES-1:0] sync_q;
  logic [CHANNELS-1:0]                 sync_out, prev_q, rise;
  logic [CHANNELS-1:0][WIDTH-1:0]      count_q;
  logic [CHANNELS-1:0]                 sticky_q;
  logic [TW-1:0]                       timer_q;
  logic                                gate_sel_q, sel_change;
  logic                                tick_int, gate;
  logic                                clear, reload, latch;

  // Input synchronisers and edge history run in every state.
  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge value of its neighbours; = here would collapse the chain.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        sync_q[k] <= {sync_q[k][SYNC_STAGES-2:0], senal[k]};
      end
      prev_q <= sync_out;
    end
  end

  always_comb begin
    sync_out = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      sync_out[k] = sync_q[k][SYNC_STAGES-1];
    end
  end

  assign rise       = sync_out & ~prev_q;
  assign sel_change = gate_sel ^ gate_sel_q;
  assign tick_int   = (state_q != IDLE) && !gate_sel && (timer_q == TIMER_LAST);
  assign gate       = gate_sel ? gate_ext : tick_int;

  // NOTE: every output of this block gets a default first, so no path through
  // the if-chain can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    clear   = 1'b0;
    reload  = 1'b0;
    latch   = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      clear   = 1'b1;
    end else if (state_q == IDLE) begin
      state_d = ARMING;
      clear   = 1'b1;
    end else if (sel_change) begin
      // A source switch invalidates the running window, even on a gate cycle.
      state_d = ARMING;
      clear   = 1'b1;
    end else if (gate) begin
      reload = 1'b1;
      if (state_q == MEASURING) begin
        latch = 1'b1;
      end else begin
        state_d = MEASURING;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      gate_sel_q <= 1'b0;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      gate_sel_q <= gate_sel;
      if (clear) begin
        timer_q <= '0;
      end else if (!gate_sel) begin
        timer_q <= (timer_q == TIMER_LAST) ? '0 : timer_q + TW'(1);
      end
    end
  end

  // Edges on a gate cycle reload the counter to 1 so they open the new window.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q  <= '0;
      sticky_q <= '0;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (clear) begin
          count_q[k]  <= '0;
          sticky_q[k] <= 1'b0;
        end else if (reload) begin
          count_q[k]  <= WIDTH'(rise[k]);
          sticky_q[k] <= 1'b0;
        end else if (rise[k]) begin
          if (count_q[k] == COUNT_MAX) begin
            sticky_q[k] <= 1'b1;
          end else begin
            count_q[k] <= count_q[k] + WIDTH'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      numero    <= '0;
      overflow  <= '0;
      valid     <= 1'b0;
      gate_tick <= 1'b0;
    end else begin
      valid     <= latch;
      gate_tick <= gate;
      if (latch) begin
        numero   <= count_q;
        overflow <= sticky_q;
      end
    end
  end

endmodule

// File: tb/tb_frecuencimetro_multi.sv
// Self-checking bench for frecuencimetro_multi: edge timestamps and gate times
// are predicted from the pin stimulus, then windowed counts are compared.
module tb_frecuencimetro_multi;

  localparam int WIDTH = 4;
  localparam int CH    = 4;
  localparam int G     = 100;
  localparam int SS    = 2;
  localparam int LAT   = SS + 1;
  localparam int MAXC  = (1 << WIDTH) - 1;

  logic                clock = 1'b0;
  logic                reset_n, enable, gate_sel, gate_ext;
  logic [CH-1:0]       senal;
  logic [CH*WIDTH-1:0] numero;
  logic [CH-1:0]       overflow;
  logic                valid, gate_tick;

  frecuencimetro_multi #(
    .WIDTH(WIDTH), .CHANNELS(CH), .GATE_CYCLES(G), .SYNC_STAGES(SS)
  ) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .gate_sel(gate_sel),
    .gate_ext(gate_ext), .senal(senal), .numero(numero), .overflow(overflow),
    .valid(valid), .gate_tick(gate_tick)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Stimulus pattern per channel: 0 = low, 1 = periodic, 2 = random bits.
  int mode [CH];
  int period [CH];
  int phase [CH];
  int ext_period = 0;
  int ext_base   = 0;

  // Reference model: cycle at which each edge reaches its counter, and the
  // cycles at which gate events become visible on gate_tick.
  int                  edges [CH][$];
  int                  ext_q [$];
  int                  int_next      = -1;
  bit                  first_pending = 1'b1;
  logic [CH*WIDTH-1:0] exp_numero    = '0;
  logic [CH-1:0]       exp_ovf       = '0;
  int                  valid_seen    = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int pos_mod(input int a, input int m);
    int r;
    r = a % m;
    return (r < 0) ? r + m : r;
  endfunction

  task automatic prune(input int bound);
    for (int k = 0; k < CH; k++) begin
      while (edges[k].size() > 0 && edges[k][0] < bound) void'(edges[k].pop_front());
    end
  endtask

  task automatic check_all(input string tag, input bit exp_tick, input bit exp_valid);
    check({tag, ".gate_tick"}, gate_tick, exp_tick);
    check({tag, ".valid"}, valid, exp_valid);
    check({tag, ".numero"}, numero, exp_numero);
    check({tag, ".overflow"}, overflow, exp_ovf);
  endtask

  // Expected outputs just after posedge number cyc.
  task automatic model_posedge();
    bit g, v;
    int n;
    g = 1'b0;
    v = 1'b0;
    if (int_next >= 0 && cyc == int_next) begin
      g = 1'b1;
      int_next += G;
    end
    if (ext_q.size() > 0 && ext_q[0] == cyc) begin
      g = 1'b1;
      void'(ext_q.pop_front());
    end
    if (g) begin
      if (!first_pending) begin
        v = 1'b1;
        valid_seen++;
        for (int k = 0; k < CH; k++) begin
          n = 0;
          foreach (edges[k][i]) if (edges[k][i] < cyc) n++;
          exp_numero[k*WIDTH +: WIDTH] = WIDTH'((n > MAXC) ? MAXC : n);
          exp_ovf[k] = (n > MAXC);
        end
      end
      prune(cyc);
      first_pending = 1'b0;
    end
    check_all("run", g, v);
  endtask

  task automatic drive();
    bit b;
    int hi;
    for (int k = 0; k < CH; k++) begin
      case (mode[k])
        1: begin
          hi = (period[k] / 2 > 0) ? period[k] / 2 : 1;
          b  = pos_mod(cyc - phase[k], period[k]) < hi;
        end
        2:       b = 1'($urandom_range(0, 1));
        default: b = 1'b0;
      endcase
      if (b && !senal[k]) edges[k].push_back(cyc + LAT);
      senal[k] = b;
    end
    if (ext_period > 0 && cyc >= ext_base && (cyc - ext_base) % ext_period == 0) begin
      gate_ext = 1'b1;
      ext_q.push_back(cyc + 1);
    end else begin
      gate_ext = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clock);
    cyc++;
    #1;
    model_posedge();
    drive();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_pattern(input int k, input int m, input int p, input int ph);
    mode[k]   = m;
    period[k] = p;
    phase[k]  = ph;
  endtask

  // Measuring starts at the next posedge; its first gate is always discarded.
  task automatic start_window(input bit internal);
    first_pending = 1'b1;
    ext_q.delete();
    int_next = internal ? cyc + 1 + G : -1;
    prune(cyc + 2);
  endtask

  task automatic change_sel(input bit sel);
    gate_sel = sel;
    if (!sel) ext_period = 0;
    start_window(!sel);
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    #1;
    exp_numero = '0;
    exp_ovf    = '0;
    int_next   = -1;
    ext_q.delete();
    check_all("async_reset", 1'b0, 1'b0);
    @(posedge clock);
    cyc++;
    #1;
    check_all("in_reset", 1'b0, 1'b0);
    reset_n = 1'b1;
    drive();
    start_window(!gate_sel);
  endtask

  initial begin
    int v0;
    reset_n  = 1'b0;
    enable   = 1'b0;
    gate_sel = 1'b0;
    gate_ext = 1'b0;
    senal    = '0;
    for (int k = 0; k < CH; k++) set_pattern(k, 2, 1, 0);

    // Reset held with toggling inputs, then released idle.
    for (int i = 0; i < 5; i++) begin
      @(posedge clock);
      cyc++;
      #1;
      check_all("reset_hold", 1'b0, 1'b0);
      drive();
    end
    reset_n = 1'b1;
    run(200);

    // Internal gate, channel 0 at one edge per 10 cycles.
    set_pattern(0, 1, 10, cyc);
    for (int k = 1; k < CH; k++) set_pattern(k, 0, 1, 0);
    enable = 1'b1;
    start_window(1'b1);
    run(4 * G + 5);
    check("ch0_ten_edges", numero[0 +: WIDTH], 64'd10);

    // Saturation on channel 1, then recovery to an exact count.
    set_pattern(1, 1, 4, cyc);
    run(3 * G);
    check("ch1_saturated", numero[WIDTH +: WIDTH], 64'(MAXC));
    check("ch1_overflow", overflow[1], 1'b1);
    set_pattern(1, 1, 20, cyc);
    run(3 * G);
    check("ch1_five_edges", numero[WIDTH +: WIDTH], 64'd5);
    check("ch1_no_overflow", overflow[1], 1'b0);

    // External gate; channel 2 edges land exactly on gate cycles.
    set_pattern(1, 0, 1, 0);
    change_sel(1'b1);
    ext_base   = cyc + 20;
    ext_period = 50;
    set_pattern(2, 1, 25, ext_base - 2);
    set_pattern(3, 2, 1, 0);
    run(50 * 6);
    check("ch2_edge_on_gate", numero[2*WIDTH +: WIDTH], 64'd2);

    // Source switch mid-window: one discarded gate, numero held meanwhile.
    while (pos_mod(cyc - ext_base, 50) != 25) run(1);
    set_pattern(2, 0, 1, 0);
    set_pattern(3, 0, 1, 0);
    v0 = valid_seen;
    change_sel(1'b0);
    run(G + 5);
    check("no_valid_after_switch", valid_seen, v0);
    run(2 * G + 5);
    check("ch0_after_switch", numero[0 +: WIDTH], 64'd10);

    // Asynchronous reset mid-window, then recovery.
    run(40);
    pulse_reset();
    run(3 * G + 10);
    check("ch0_after_reset", numero[0 +: WIDTH], 64'd10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
